// File: rtl/adr_sequencer.sv
// adr_sequencer: drives ADR_TRIGGER_N to the PCH on a power-fail event, waits
// for ADR_COMPLETE (plus an eADR cache-flush hold), then pulses the ADR ack.
// Optional feature macro: ADR_SEQ_DEBUG_CNT_EN (trigger/timeout event counters).
module adr_sequencer #(
  parameter int unsigned ADR_TIMEOUT_CYC = 2000,
  parameter int unsigned EADR_HOLD_CYC   = 100,
  parameter int unsigned ACK_PULSE_CYC   = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iAdrMode0,
  input  logic       iAdrMode1,
  input  logic       iAdrComplete,
  input  logic       iPwrFail_n,
  input  logic       iSlpS3_n,
  output logic       oAdrTrigger_n,
  output logic       oAdrAck,
  output logic       oAdrBusy,
  output logic       oAdrTimeout,
  output logic       oAdrDone,
  output logic [2:0] oState,
  output logic [7:0] oAdrEvtCnt
);

  localparam int unsigned MAX_AB  = (ADR_TIMEOUT_CYC > EADR_HOLD_CYC) ? ADR_TIMEOUT_CYC : EADR_HOLD_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > ACK_PULSE_CYC) ? MAX_AB : ACK_PULSE_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ADR_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(EADR_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_PULSE_CYC - 1);

  localparam logic [1:0] MODE_LEGACY = 2'b01;
  localparam logic [1:0] MODE_EADR   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIGGER = 3'd1,
    S_WAIT    = 3'd2,
    S_HOLD    = 3'd3,
    S_ACK     = 3'd4,
    S_DONE    = 3'd5,
    S_TIMEOUT = 3'd6
  } state_t;

  logic             r_pf_s1, r_pf_s2;
  logic             r_cm_s1, r_cm_s2, r_cm_s3;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_in;
  logic             w_mode_ok, w_rise;
  logic             r_trig_n, r_ack, r_busy, r_timeout, r_done;
  logic             w_trig_n_nxt, w_ack_nxt, w_busy_nxt, w_timeout_nxt, w_done_nxt;

  assign w_mode_in = {iAdrMode1, iAdrMode0};
  assign w_mode_ok = (w_mode_in == MODE_LEGACY) || (w_mode_in == MODE_EADR);
  assign w_rise    = r_cm_s2 & ~r_cm_s3;

  // Two-flop synchronizers; third complete stage gives the rising-edge reference
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_pf_s1 <= 1'b1;
      r_pf_s2 <= 1'b1;
      r_cm_s1 <= 1'b0;
      r_cm_s2 <= 1'b0;
      r_cm_s3 <= 1'b0;
    end else begin
      r_pf_s1 <= iPwrFail_n;
      r_pf_s2 <= r_pf_s1;
      r_cm_s1 <= iAdrComplete;
      r_cm_s2 <= r_cm_s1;
      r_cm_s3 <= r_cm_s2;
    end
  end

  // State register, shared per-state cycle counter and captured mode
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
      if (r_state == S_IDLE && w_state_nxt == S_TRIGGER) r_mode <= w_mode_in;
    end
  end

  // Next-state logic; S3 exit aborts any active state, complete edge beats timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (!r_pf_s2 && iSlpS3_n && w_mode_ok) w_state_nxt = S_TRIGGER;
      S_TRIGGER: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_rise)                 w_state_nxt = (r_mode == MODE_EADR) ? S_HOLD : S_ACK;
        else if (r_cnt == TO_LAST)  w_state_nxt = S_TIMEOUT;
      end
      S_HOLD:    if (r_cnt == HOLD_LAST) w_state_nxt = S_ACK;
      S_ACK:     if (r_cnt == ACK_LAST)  w_state_nxt = S_DONE;
      S_DONE:    if (!iSlpS3_n) w_state_nxt = S_IDLE;
      S_TIMEOUT: if (!iSlpS3_n) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (!iSlpS3_n && (r_state == S_TRIGGER || r_state == S_WAIT ||
                      r_state == S_HOLD    || r_state == S_ACK))
      w_state_nxt = S_IDLE;
  end

  // Output decode from the next state so registered outputs align with oState
  always_comb begin
    w_trig_n_nxt  = 1'b1;
    w_ack_nxt     = 1'b0;
    w_busy_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    case (w_state_nxt)
      S_TRIGGER, S_WAIT, S_HOLD: begin
        w_trig_n_nxt = 1'b0;
        w_busy_nxt   = 1'b1;
      end
      S_ACK: begin
        w_trig_n_nxt = 1'b0;
        w_busy_nxt   = 1'b1;
        w_ack_nxt    = 1'b1;
      end
      S_DONE:    w_done_nxt    = 1'b1;
      S_TIMEOUT: w_timeout_nxt = 1'b1;
      default:   ;
    endcase
  end

  // Output registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_trig_n  <= 1'b1;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_trig_n  <= w_trig_n_nxt;
      r_ack     <= w_ack_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign oAdrTrigger_n = r_trig_n;
  assign oAdrAck       = r_ack;
  assign oAdrBusy      = r_busy;
  assign oAdrTimeout   = r_timeout;
  assign oAdrDone      = r_done;
  assign oState        = r_state;

`ifdef ADR_SEQ_DEBUG_CNT_EN
  logic [3:0] r_trg_cnt, r_to_cnt;

  // Saturating trigger/timeout entry counters, cleared only by reset
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_trg_cnt <= 4'h0;
      r_to_cnt  <= 4'h0;
    end else begin
      if (r_state != S_TRIGGER && w_state_nxt == S_TRIGGER && r_trg_cnt != 4'hF)
        r_trg_cnt <= r_trg_cnt + 4'd1;
      if (r_state != S_TIMEOUT && w_state_nxt == S_TIMEOUT && r_to_cnt != 4'hF)
        r_to_cnt <= r_to_cnt + 4'd1;
    end
  end

  assign oAdrEvtCnt = {r_trg_cnt, r_to_cnt};
`else
  assign oAdrEvtCnt = 8'h00;
`endif

endmodule

// File: tb/tb_adr_sequencer.sv
// tb_adr_sequencer: directed stimulus for adr_sequencer with a phase/elapsed
// behavioural model checked every cycle, plus hand-computed pin checks.
`timescale 1ns/1ps
module tb_adr_sequencer;

  localparam int TO_CYC   = 2000;
  localparam int HOLD_CYC = 100;
  localparam int ACK_CYC  = 4;
`ifdef ADR_SEQ_DEBUG_CNT_EN
  localparam int EXP_CNT = 'hF2;
`else
  localparam int EXP_CNT = 'h00;
`endif

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic       iAdrMode0, iAdrMode1, iAdrComplete, iPwrFail_n, iSlpS3_n;
  logic       oAdrTrigger_n, oAdrAck, oAdrBusy, oAdrTimeout, oAdrDone;
  logic [2:0] oState;
  logic [7:0] oAdrEvtCnt;

  adr_sequencer dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iAdrMode0(iAdrMode0), .iAdrMode1(iAdrMode1),
    .iAdrComplete(iAdrComplete), .iPwrFail_n(iPwrFail_n), .iSlpS3_n(iSlpS3_n),
    .oAdrTrigger_n(oAdrTrigger_n), .oAdrAck(oAdrAck), .oAdrBusy(oAdrBusy),
    .oAdrTimeout(oAdrTimeout), .oAdrDone(oAdrDone),
    .oState(oState), .oAdrEvtCnt(oAdrEvtCnt)
  );

  always #5 iClk = ~iClk;

  // Model: phase number, cycles spent in it, sampled-input histories, event tallies
  int   m_ph = 0, m_el = 0, m_nx = 0, m_trg = 0, m_to = 0;
  bit   m_pf0 = 1, m_pf1 = 1, m_cm0 = 0, m_cm1 = 0, m_cm2 = 0;
  bit   m_rise, m_pfs;
  int   m_mode = 0;

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      m_ph = 0; m_el = 0; m_trg = 0; m_to = 0; m_mode = 0;
      m_pf0 = 1; m_pf1 = 1; m_cm0 = 0; m_cm1 = 0; m_cm2 = 0;
    end else begin
      m_pfs  = m_pf1;
      m_rise = m_cm1 && !m_cm2;
      m_nx   = m_ph;
      case (m_ph)
        0: if (!m_pfs && iSlpS3_n && ({iAdrMode1, iAdrMode0} == 2'b01 || {iAdrMode1, iAdrMode0} == 2'b10)) begin
             m_nx = 1;
             m_mode = int'({iAdrMode1, iAdrMode0});
           end
        1: m_nx = 2;
        2: if (m_rise) m_nx = (m_mode == 2) ? 3 : 4;
           else if (m_el + 1 == TO_CYC) m_nx = 6;
        3: if (m_el + 1 == HOLD_CYC) m_nx = 4;
        4: if (m_el + 1 == ACK_CYC) m_nx = 5;
        default: if (!iSlpS3_n) m_nx = 0;
      endcase
      if (m_ph >= 1 && m_ph <= 4 && !iSlpS3_n) m_nx = 0;
      if (m_ph == 0 && m_nx == 1 && m_trg < 15) m_trg++;
      if (m_ph != 6 && m_nx == 6 && m_to < 15) m_to++;
      m_el = (m_nx == m_ph) ? m_el + 1 : 0;
      m_ph = m_nx;
      m_pf1 = m_pf0; m_pf0 = iPwrFail_n;
      m_cm2 = m_cm1; m_cm1 = m_cm0; m_cm0 = iAdrComplete;
    end
  end

  function automatic logic [15:0] model_vec();
    logic act_seq;
    logic [7:0] cnt;
    act_seq = (m_ph >= 1 && m_ph <= 4);
`ifdef ADR_SEQ_DEBUG_CNT_EN
    cnt = {4'(m_trg), 4'(m_to)};
`else
    cnt = 8'h00;
`endif
    return {~act_seq, m_ph == 4, act_seq, m_ph == 6, m_ph == 5, 3'(m_ph), cnt};
  endfunction

  int cyc_vec = 0, cyc_err = 0, pin_vec = 0, pin_err = 0;
  logic [15:0] c_act, c_exp;

  // Every-cycle comparison of the full output bundle against the model
  always @(negedge iClk) begin
    c_act = {oAdrTrigger_n, oAdrAck, oAdrBusy, oAdrTimeout, oAdrDone, oState, oAdrEvtCnt};
    c_exp = model_vec();
    cyc_vec++;
    if (c_act !== c_exp) begin
      cyc_err++;
      $display("FAIL cycle_cmp t=%0t got=%h expected=%h", $time, c_act, c_exp);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    pin_vec++;
    if (act != exp) begin
      pin_err++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic ret_idle();
    iSlpS3_n = 1'b0; step(1);
    iPwrFail_n = 1'b1; iAdrComplete = 1'b0; step(4);
    iSlpS3_n = 1'b1; step(1);
  endtask

  initial begin
    iRst_n = 1'b0; iPwrFail_n = 1'b1; iSlpS3_n = 1'b1; iAdrComplete = 1'b0;
    {iAdrMode1, iAdrMode0} = 2'b01;
    step(3);
    chk("rst_trig_n", oAdrTrigger_n, 1);
    chk("rst_state", oState, 0);
    chk("rst_evtcnt", oAdrEvtCnt, 0);
    iRst_n = 1'b1; step(2);

    // async reset in the middle of WAIT_CMPL
    iPwrFail_n = 1'b0; step(4);
    chk("pre_rst_state", oState, 2);
    #2 iRst_n = 1'b0; iPwrFail_n = 1'b1;
    #1 chk("async_rst_trig_n", oAdrTrigger_n, 1);
    chk("async_rst_state", oState, 0);
    step(2); iRst_n = 1'b1; step(2);

    // legacy ADR
    iPwrFail_n = 1'b0; step(2);
    chk("leg_idle_sync", oState, 0);
    step(1);
    chk("leg_trig_state", oState, 1);
    chk("leg_trig_n", oAdrTrigger_n, 0);
    step(47); iAdrComplete = 1'b1; step(2);
    chk("leg_wait", oState, 2);
    step(1);
    chk("leg_ack", oAdrAck, 1);
    step(3);
    chk("leg_ack_last", oAdrAck, 1);
    step(1);
    chk("leg_done", oAdrDone, 1);
    chk("leg_done_trig_n", oAdrTrigger_n, 1);
    chk("leg_done_ack", oAdrAck, 0);
    ret_idle();

    // eADR, power-fail releasing mid-sequence must not abort
    {iAdrMode1, iAdrMode0} = 2'b10;
    iPwrFail_n = 1'b0; step(50); iAdrComplete = 1'b1; iPwrFail_n = 1'b1; step(3);
    chk("eadr_hold", oState, 3);
    step(99);
    chk("eadr_hold_last", oState, 3);
    chk("eadr_no_ack_yet", oAdrAck, 0);
    step(1);
    chk("eadr_ack", oAdrAck, 1);
    step(4);
    chk("eadr_done", oState, 5);
    ret_idle();

    // timeout with complete held low
    {iAdrMode1, iAdrMode0} = 2'b01;
    iPwrFail_n = 1'b0; step(2003);
    chk("to_wait_last", oState, 2);
    step(1);
    chk("to_state", oState, 6);
    chk("to_flag", oAdrTimeout, 1);
    chk("to_trig_n", oAdrTrigger_n, 1);
    iSlpS3_n = 1'b0; step(1);
    chk("to_idle", oState, 0);
    chk("to_flag_clr", oAdrTimeout, 0);
    ret_idle();

    // disabled / reserved modes stay idle
    {iAdrMode1, iAdrMode0} = 2'b00;
    iPwrFail_n = 1'b0; step(10);
    chk("dis00_state", oState, 0);
    {iAdrMode1, iAdrMode0} = 2'b11; step(10);
    chk("dis11_trig_n", oAdrTrigger_n, 1);
    iPwrFail_n = 1'b1; step(4);

    // stale complete is not an edge
    iAdrComplete = 1'b1; step(4);
    {iAdrMode1, iAdrMode0} = 2'b01;
    iPwrFail_n = 1'b0; step(2004);
    chk("stale_timeout", oState, 6);
    ret_idle();

    // abort from HOLD
    {iAdrMode1, iAdrMode0} = 2'b10;
    iPwrFail_n = 1'b0; step(20); iAdrComplete = 1'b1; step(3);
    chk("abort_in_hold", oState, 3);
    step(10); iSlpS3_n = 1'b0; step(1);
    chk("abort_idle", oState, 0);
    chk("abort_trig_n", oAdrTrigger_n, 1);
    chk("abort_ack", oAdrAck, 0);
    ret_idle();

    // twelve more short triggers aborted from TRIGGER: 17 triggers, 2 timeouts total
    {iAdrMode1, iAdrMode0} = 2'b01;
    for (int i = 0; i < 12; i++) begin
      iPwrFail_n = 1'b0; step(3);
      iSlpS3_n = 1'b0; step(1);
      iPwrFail_n = 1'b1; step(4);
      iSlpS3_n = 1'b1; step(1);
    end
    chk("evt_cnt", oAdrEvtCnt, EXP_CNT);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", cyc_vec + pin_vec, cyc_err + pin_err);
    $finish;
  end

endmodule
